// File: rtl/scope_pkg.sv
// scope_pkg: shared constants for the scope SPI slave front end.
// Byte width, bit-counter width and the default mid-byte idle limit.
package scope_pkg;

    localparam int SPI_BITS        = 8;
    localparam int CNT_W           = $clog2(SPI_BITS);
    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/scope_sync.sv
// scope_sync: STAGES-deep synchroniser with registered rise/fall events.
// Ports: clk, reset_n (async low), d (async in), rise/fall (1-cycle events).
module scope_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        dly_d  = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~dly_q;
        fall_d = ~sync_q[STAGES-1] & dly_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/scope_spi.sv
// scope_spi: SPI mode-0 slave, bytes out on dout/drequest, din shifted on miso.
// Ports: clk, reset_n, sclk/mosi/ss_n in, miso/miso_oe/select/dout/drequest/
// frame_err out, din in. Option macro SCOPE_SPI_TIMEOUT_EN adds a mid-byte
// idle timeout of TIMEOUT_CYC clocks.
module scope_spi
    import scope_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                ss_n,
    output logic                miso,
    output logic                miso_oe,
    output logic                select,
    output logic [SPI_BITS-1:0] dout,
    output logic                drequest,
    input  logic [SPI_BITS-1:0] din,
    output logic                frame_err
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic sclk_rise, sclk_fall;
    logic ss_rise, ss_fall;

    scope_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // ss_n idles high, so its chain resets high to avoid a false deselect.
    scope_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ss_n),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    // One stage longer than the sync chain so it lines up with the
    // registered sclk event.
    logic [SYNC_STAGES:0] mosi_q, mosi_d;
    logic                 mosi_s;

    assign mosi_d = {mosi_q[SYNC_STAGES-1:0], mosi};
    assign mosi_s = mosi_q[SYNC_STAGES];

    // rx/tx keep only the bits still needed: rx's top bit and din[7]
    // go straight to dout and miso respectively.
    logic                select_q, select_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SPI_BITS-2:0] rx_q, rx_d;
    logic [SPI_BITS-2:0] tx_q, tx_d;
    logic                miso_q, miso_d;
    logic [SPI_BITS-1:0] dout_q, dout_d;
    logic                drequest_q, drequest_d;
    logic                ferr_q, ferr_d;

`ifdef SCOPE_SPI_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    always_comb begin
        select_d   = select_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        dout_d     = dout_q;
        drequest_d = 1'b0;
        ferr_d     = ferr_q;
`ifdef SCOPE_SPI_TIMEOUT_EN
        idle_d     = '0;
`endif
        if (ss_fall) begin
            select_d = 1'b1;
            cnt_d    = '0;
            tx_d     = din[SPI_BITS-2:0];
            miso_d   = din[SPI_BITS-1];
            ferr_d   = 1'b0;
        end else if (ss_rise) begin
            // Deselect beats a coincident sclk event, so an 8th rise
            // landing here is lost and counted as a short frame.
            if (select_q) begin
                select_d = 1'b0;
                miso_d   = 1'b0;
                cnt_d    = '0;
                if (cnt_q != '0) begin
                    ferr_d = 1'b1;
                end
            end
        end else if (select_q) begin
            if (sclk_rise) begin
                rx_d  = {rx_q[SPI_BITS-3:0], mosi_s};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SPI_BITS - 1)) begin
                    dout_d     = {rx_q, mosi_s};
                    drequest_d = 1'b1;
                end
            end else if (sclk_fall) begin
                if (cnt_q == '0) begin
                    tx_d   = din[SPI_BITS-2:0];
                    miso_d = din[SPI_BITS-1];
                end else begin
                    tx_d   = {tx_q[SPI_BITS-3:0], 1'b0};
                    miso_d = tx_q[SPI_BITS-2];
                end
            end
`ifdef SCOPE_SPI_TIMEOUT_EN
            if (!sclk_rise && !sclk_fall && cnt_q != '0) begin
                if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    cnt_d  = '0;
                    rx_d   = '0;
                    tx_d   = din[SPI_BITS-2:0];
                    miso_d = din[SPI_BITS-1];
                    ferr_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_q     <= '0;
            select_q   <= 1'b0;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            dout_q     <= '0;
            drequest_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            mosi_q     <= mosi_d;
            select_q   <= select_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            dout_q     <= dout_d;
            drequest_q <= drequest_d;
            ferr_q     <= ferr_d;
        end
    end

`ifdef SCOPE_SPI_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign miso      = miso_q;
    assign miso_oe   = select_q;
    assign select    = select_q;
    assign dout      = dout_q;
    assign drequest  = drequest_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_scope_spi.sv
// tb_scope_spi: directed bench for scope_spi.
// Bit-banged SPI master plus a din responder that answers dout + 8'h42.
module tb_scope_spi;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso;
    logic       miso_oe;
    logic       select;
    logic [7:0] dout;
    logic       drequest;
    logic [7:0] din = 8'h00;
    logic       frame_err;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   drq_cnt = 0;
    logic       pre_req = 1'b0;
    logic [7:0] pre_val = 8'h00;

    scope_spi #(.SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .select    (select),
        .dout      (dout),
        .drequest  (drequest),
        .din       (din),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Upstream stand-in: counts strobes, answers each byte with dout+42.
    always @(negedge clk) begin
        if (drequest) begin
            drq_cnt = drq_cnt + 1;
            din = dout + 8'h42;
        end else if (pre_req) begin
            din = pre_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_din(input logic [7:0] v);
        pre_val = v;
        pre_req = 1'b1;
        wait_clk(1);
        pre_req = 1'b0;
    endtask

    task automatic sel();
        ss_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic desel();
        wait_clk(6);
        ss_n = 1'b1;
        wait_clk(8);
    endtask

    // Mode 0: master reads miso just before raising sclk.
    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_clk(5);
            r = {r[6:0], miso};
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_select"},   32'(select),    32'h0);
        chk({tag, "_miso"},     32'(miso),      32'h0);
        chk({tag, "_miso_oe"},  32'(miso_oe),   32'h0);
        chk({tag, "_drequest"}, 32'(drequest),  32'h0);
        chk({tag, "_ferr"},     32'(frame_err), 32'h0);
        chk({tag, "_dout"},     32'(dout),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int         d0;

        #1;
        check_all_zero("rst0");
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);

        // Single transfer then a second byte returning the staged answer.
        set_din(8'h42);
        sel();
        chk("sel_up", 32'(select), 32'h1);
        chk("oe_up",  32'(miso_oe), 32'h1);
        d0 = drq_cnt;
        spi_bits(8'h11, 8, r);
        chk("xfer1_miso", 32'(r), 32'h42);
        chk("xfer1_dout", 32'(dout), 32'h11);
        chk("xfer1_drq",  32'(drq_cnt - d0), 32'h1);
        spi_bits(8'h3C, 8, r);
        chk("xfer2_miso", 32'(r), 32'h53);
        chk("xfer2_dout", 32'(dout), 32'h3C);
        chk("xfer2_drq",  32'(drq_cnt - d0), 32'h2);
        desel();
        chk("xfer_ferr", 32'(frame_err), 32'h0);
        chk("desel_miso", 32'(miso), 32'h0);

        // Reset in the middle of a byte.
        sel();
        spi_bits(8'hF0, 4, r);
        reset_n = 1'b0;
        ss_n = 1'b1;
        #1;
        check_all_zero("rst_mid");
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        set_din(8'h7E);
        sel();
        d0 = drq_cnt;
        spi_bits(8'hC3, 8, r);
        desel();
        chk("rec_miso", 32'(r), 32'h7E);
        chk("rec_dout", 32'(dout), 32'hC3);
        chk("rec_drq",  32'(drq_cnt - d0), 32'h1);
        chk("rec_ferr", 32'(frame_err), 32'h0);

        // Burst of three bytes under one select.
        set_din(8'h42);
        sel();
        d0 = drq_cnt;
        spi_bits(8'h16, 8, r);
        chk("b1_miso", 32'(r), 32'h42);
        chk("b1_dout", 32'(dout), 32'h16);
        spi_bits(8'hAA, 8, r);
        chk("b2_miso", 32'(r), 32'h58);
        chk("b2_dout", 32'(dout), 32'hAA);
        spi_bits(8'h55, 8, r);
        chk("b3_miso", 32'(r), 32'hEC);
        chk("b3_dout", 32'(dout), 32'h55);
        desel();
        chk("burst_drq",  32'(drq_cnt - d0), 32'h3);
        chk("burst_ferr", 32'(frame_err), 32'h0);

        // Short frame: 5 bits then deselect.
        sel();
        d0 = drq_cnt;
        spi_bits(8'hFF, 5, r);
        desel();
        chk("short_drq",  32'(drq_cnt - d0), 32'h0);
        chk("short_ferr", 32'(frame_err), 32'h1);
        chk("short_dout", 32'(dout), 32'h55);
        sel();
        chk("short_clr", 32'(frame_err), 32'h0);
        spi_bits(8'h5A, 8, r);
        desel();
        chk("short_next_dout", 32'(dout), 32'h5A);
        chk("short_next_drq",  32'(drq_cnt - d0), 32'h1);
        chk("short_next_ferr", 32'(frame_err), 32'h0);

        // 8th rise and deselect land on the same clock.
        sel();
        d0 = drq_cnt;
        spi_bits(8'hE7, 7, r);
        mosi = 1'b1;
        wait_clk(5);
        sclk = 1'b1;
        ss_n = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
        wait_clk(8);
        chk("same_drq",  32'(drq_cnt - d0), 32'h0);
        chk("same_ferr", 32'(frame_err), 32'h1);
        chk("same_dout", 32'(dout), 32'h5A);

        // Master stalls after 3 bits.
        sel();
        d0 = drq_cnt;
        spi_bits(8'hA0, 3, r);
        wait_clk(20);
        spi_bits(8'h3C, 8, r);
        desel();
`ifdef SCOPE_SPI_TIMEOUT_EN
        chk("tmo_dout", 32'(dout), 32'h3C);
`else
        chk("tmo_dout", 32'(dout), 32'hA7);
`endif
        chk("tmo_drq",  32'(drq_cnt - d0), 32'h1);
        chk("tmo_ferr", 32'(frame_err), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
